// File: rtl/stream_mux_2x1.sv
// Two-to-one valid/ready stream merger with round-robin arbitration,
// a single registered output stage, source tagging and per-input beat counters.
module stream_mux_2x1 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din_0,
  input  logic              din_0_valid,
  output logic              din_0_ready,
  input  logic [DATA_W-1:0] din_1,
  input  logic              din_1_valid,
  output logic              din_1_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_src,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [CNT_W-1:0]  cnt_0,
  output logic [CNT_W-1:0]  cnt_1
);

  logic last_grant_r;
  logic load_ok_s;
  logic grant_0_s;
  logic grant_1_s;
  logic accept_0_s;
  logic accept_1_s;

  // Round-robin grant: on contention serve the source not served last.
  always_comb begin
    grant_0_s = 1'b0;
    grant_1_s = 1'b0;
    if (din_0_valid && din_1_valid) begin
      if (last_grant_r) begin
        grant_0_s = 1'b1;
      end else begin
        grant_1_s = 1'b1;
      end
    end else if (din_0_valid) begin
      grant_0_s = 1'b1;
    end else if (din_1_valid) begin
      grant_1_s = 1'b1;
    end else begin
      grant_0_s = 1'b0;
      grant_1_s = 1'b0;
    end
  end

  // The output register can take a beat when empty or draining this cycle.
  assign load_ok_s   = ~dout_valid | dout_ready;
  assign din_0_ready = rst_n & load_ok_s & grant_0_s;
  assign din_1_ready = rst_n & load_ok_s & grant_1_s;
  assign accept_0_s  = din_0_valid & din_0_ready;
  assign accept_1_s  = din_1_valid & din_1_ready;

  // Output stage, arbitration history and beat counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout         <= {DATA_W{1'b0}};
      dout_src     <= 1'b0;
      dout_valid   <= 1'b0;
      last_grant_r <= 1'b1;
      cnt_0        <= {CNT_W{1'b0}};
      cnt_1        <= {CNT_W{1'b0}};
    end else if (accept_0_s) begin
      dout         <= din_0;
      dout_src     <= 1'b0;
      dout_valid   <= 1'b1;
      last_grant_r <= 1'b0;
      cnt_0        <= cnt_0 + CNT_W'(1);
    end else if (accept_1_s) begin
      dout         <= din_1;
      dout_src     <= 1'b1;
      dout_valid   <= 1'b1;
      last_grant_r <= 1'b1;
      cnt_1        <= cnt_1 + CNT_W'(1);
    end else if (dout_valid && dout_ready) begin
      dout_valid   <= 1'b0;
    end else begin
      dout_valid   <= dout_valid;
    end
  end

endmodule
